// File: rtl/msrv32_mem_arb_pkg.sv
// msrv32_mem_arb_pkg: shared encodings for the unified-memory arbiter
package msrv32_mem_arb_pkg;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ADDR = 2'b01;
  localparam logic [1:0] S_DATA = 2'b10;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/msrv32_mem_arbiter_if.sv
// msrv32_mem_arbiter_if: AHB-lite-style memory master port shared by fetch and load/store
interface msrv32_mem_arbiter_if;
  logic [31:0] m_haddr_out;
  logic [1:0] m_htrans_out;
  logic m_hwrite_out;
  logic [3:0] m_hmask_out;
  logic [31:0] m_hwdata_out;
  logic [31:0] m_hrdata_in;
  logic m_hready_in;
  logic m_hresp_in;
  modport master(output m_haddr_out, m_htrans_out, m_hwrite_out, m_hmask_out, m_hwdata_out,
                 input m_hrdata_in, m_hready_in, m_hresp_in);
  modport slave(input m_haddr_out, m_htrans_out, m_hwrite_out, m_hmask_out, m_hwdata_out,
                output m_hrdata_in, m_hready_in, m_hresp_in);
endinterface

// File: rtl/msrv32_wait_timer.sv
// msrv32_wait_timer: counts consecutive wait-state cycles, flags when MAX_WAIT is reached
module msrv32_wait_timer #(
  parameter int MAX_WAIT = 255
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? 8'd0 : en ? cnt + 8'd1 : cnt;
  assign expired = cnt == 8'(MAX_WAIT);
endmodule

// File: rtl/msrv32_mem_arbiter.sv
// msrv32_mem_arbiter: shares one memory port between fetch and load/store, with
// alternating priority on contention and a watchdog that turns a hung slave into an error.
module msrv32_mem_arbiter
  import msrv32_mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input logic clk_in,
  input logic rst_in,
  input logic [31:0] i_addr_in,
  input logic i_req_in,
  output logic [31:0] i_rdata_out,
  output logic i_hready_out,
  output logic i_hresp_out,
  input logic [1:0] d_htrans_in,
  input logic d_wr_req_in,
  input logic [31:0] d_addr_in,
  input logic [31:0] d_wdata_in,
  input logic [3:0] d_mask_in,
  output logic [31:0] d_rdata_out,
  output logic d_hready_out,
  output logic d_hresp_out,
  msrv32_mem_arbiter_if.master m
);
  logic [1:0] state, state_nxt;
  logic owner, last_d, expired, i_elig, d_elig, gnt_d, gnt_i, abort, done, resp, upd_d;
  logic [31:0] wdata_q, rd;
  // a requester whose hready_out is high this cycle is being retired, so it is not eligible
  always_comb begin
    i_elig = i_req_in && !i_hready_out;
    d_elig = d_htrans_in == HTRANS_NONSEQ && !d_hready_out;
    gnt_d = d_elig && (!i_elig || !last_d);
    gnt_i = i_elig && !gnt_d;
    abort = state != S_IDLE && !m.m_hready_in && expired;
    done = abort || (state == S_DATA && m.m_hready_in);
    resp = abort || m.m_hresp_in;
    rd = abort ? 32'd0 : m.m_hrdata_in;
    upd_d = abort || !m.m_hwrite_out;
    state_nxt = state == S_IDLE ? ((gnt_d || gnt_i) ? S_ADDR : S_IDLE) :
                abort ? S_IDLE :
                !m.m_hready_in ? state :
                state == S_ADDR ? S_DATA : S_IDLE;
  end
  msrv32_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk_in),
    .rst(rst_in),
    .clr(state_nxt != state),
    .en(state != S_IDLE && !m.m_hready_in),
    .expired(expired)
  );
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= S_IDLE;
      owner <= OWN_I;
      last_d <= 1'b0;
      wdata_q <= '0;
      i_rdata_out <= '0;
      i_hready_out <= 1'b0;
      i_hresp_out <= 1'b0;
      d_rdata_out <= '0;
      d_hready_out <= 1'b0;
      d_hresp_out <= 1'b0;
      m.m_haddr_out <= '0;
      m.m_htrans_out <= HTRANS_IDLE;
      m.m_hwrite_out <= 1'b0;
      m.m_hmask_out <= '0;
      m.m_hwdata_out <= '0;
    end else begin
      state <= state_nxt;
      i_hready_out <= done && owner == OWN_I;
      i_hresp_out <= done && owner == OWN_I && resp;
      d_hready_out <= done && owner == OWN_D;
      d_hresp_out <= done && owner == OWN_D && resp;
      if (done && owner == OWN_I) i_rdata_out <= rd;
      if (done && owner == OWN_D && upd_d) d_rdata_out <= rd;
      if (state == S_IDLE && (gnt_d || gnt_i)) begin
        owner <= gnt_d;
        last_d <= gnt_d;
        wdata_q <= d_wdata_in;
        m.m_haddr_out <= gnt_d ? d_addr_in : i_addr_in & ~32'h3;
        m.m_htrans_out <= HTRANS_NONSEQ;
        m.m_hwrite_out <= gnt_d && d_wr_req_in;
        m.m_hmask_out <= (gnt_d && d_wr_req_in) ? d_mask_in : 4'hF;
      end
      if (state == S_ADDR && state_nxt != S_ADDR) m.m_htrans_out <= HTRANS_IDLE;
      if (state == S_ADDR && state_nxt == S_DATA) m.m_hwdata_out <= wdata_q;
    end
endmodule

// File: tb/tb_msrv32_mem_arbiter.sv
// tb_msrv32_mem_arbiter: scenario tasks with a completion scoreboard for msrv32_mem_arbiter
module tb_msrv32_mem_arbiter;
  typedef struct packed {
    logic own;
    logic [31:0] rdata;
    logic resp;
  } exp_t;
  localparam logic [31:0] K = 32'h5A5A_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, rd_fixed = '0;
  logic i_req = 1'b0, d_wr = 1'b0, use_fn = 1'b0;
  logic [1:0] d_htrans = 2'b00;
  logic [3:0] d_mask = '0;
  logic [31:0] i_rdata_out, d_rdata_out;
  logic i_hready_out, i_hresp_out, d_hready_out, d_hresp_out;
  int errors = 0, checks = 0;
  exp_t sb[$];
  msrv32_mem_arbiter_if mif();
  always_comb mif.m_hrdata_in = use_fn ? (mif.m_haddr_out ^ K) : rd_fixed;
  msrv32_mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk_in(clk), .rst_in(rst),
    .i_addr_in(i_addr), .i_req_in(i_req), .i_rdata_out(i_rdata_out),
    .i_hready_out(i_hready_out), .i_hresp_out(i_hresp_out),
    .d_htrans_in(d_htrans), .d_wr_req_in(d_wr), .d_addr_in(d_addr), .d_wdata_in(d_wdata),
    .d_mask_in(d_mask), .d_rdata_out(d_rdata_out), .d_hready_out(d_hready_out),
    .d_hresp_out(d_hresp_out), .m(mif)
  );
  always #5 clk = ~clk;
  task automatic test_reset;
    rst = 1'b1;
    mif.m_hready_in = 1'b1;
    mif.m_hresp_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mif.m_htrans_out, i_hready_out, d_hready_out, i_hresp_out, d_hresp_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000000", {mif.m_htrans_out, i_hready_out, d_hready_out, i_hresp_out, d_hresp_out});
    end
    checks++;
    if ({i_rdata_out, d_rdata_out} !== 64'b0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata_out, d_rdata_out);
    end
    rst = 1'b0;
  endtask
  task automatic test_fetch;
    exp_t e;
    sb.delete();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h103; rd_fixed = 32'h13; use_fn = 1'b0;
    sb.push_back('{1'b0, 32'h13, 1'b0});
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({mif.m_htrans_out, mif.m_haddr_out, mif.m_hmask_out, mif.m_hwrite_out} !== {2'b10, 32'h100, 4'hF, 1'b0}) begin
          errors++;
          $display("FAIL fetch_addr: got htrans=%b haddr=%h hmask=%h hwrite=%b want 10/00000100/f/0",
                   mif.m_htrans_out, mif.m_haddr_out, mif.m_hmask_out, mif.m_hwrite_out);
        end
      end
      if (c != 1) begin
        checks++;
        if (mif.m_htrans_out !== 2'b00) begin
          errors++;
          $display("FAIL fetch_htrans_c%0d: got %b want 00", c, mif.m_htrans_out);
        end
      end
      if (c == 3) i_req = 1'b0;
      checks++;
      if ({i_hready_out, d_hready_out} !== {c == 3, 1'b0}) begin
        errors++;
        $display("FAIL fetch_pulse_c%0d: got %b want %b", c, {i_hready_out, d_hready_out}, {c == 3, 1'b0});
      end
      if (i_hready_out && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({1'b0, i_rdata_out, i_hresp_out} !== e) begin
          errors++;
          $display("FAIL fetch_data: got rdata=%h resp=%b want rdata=%h resp=%b", i_rdata_out, i_hresp_out, e.rdata, e.resp);
        end
      end
    end
  endtask
  task automatic test_write_wait;
    exp_t e;
    sb.delete();
    @(negedge clk);
    d_htrans = 2'b10; d_wr = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_mask = 4'b0011;
    sb.push_back('{1'b1, d_rdata_out, 1'b0});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({mif.m_htrans_out, mif.m_haddr_out, mif.m_hwrite_out, mif.m_hmask_out} !== {2'b10, 32'h2004, 1'b1, 4'b0011}) begin
          errors++;
          $display("FAIL write_addr: got htrans=%b haddr=%h hwrite=%b hmask=%b want 10/00002004/1/0011",
                   mif.m_htrans_out, mif.m_haddr_out, mif.m_hwrite_out, mif.m_hmask_out);
        end
        d_htrans = 2'b00;
      end
      if (c == 2) begin
        checks++;
        if ({mif.m_htrans_out, mif.m_hwdata_out, mif.m_hmask_out} !== {2'b00, 32'hDEADBEEF, 4'b0011}) begin
          errors++;
          $display("FAIL write_data: got htrans=%b hwdata=%h hmask=%b want 00/deadbeef/0011",
                   mif.m_htrans_out, mif.m_hwdata_out, mif.m_hmask_out);
        end
        mif.m_hready_in = 1'b0;
      end
      if (c == 4) mif.m_hready_in = 1'b1;
      checks++;
      if ({i_hready_out, d_hready_out} !== {1'b0, c == 5}) begin
        errors++;
        $display("FAIL write_pulse_c%0d: got %b want %b", c, {i_hready_out, d_hready_out}, {1'b0, c == 5});
      end
      if (d_hready_out && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({1'b1, d_rdata_out, d_hresp_out} !== e) begin
          errors++;
          $display("FAIL write_resp: got rdata=%h resp=%b want rdata=%h resp=%b", d_rdata_out, d_hresp_out, e.rdata, e.resp);
        end
      end
    end
    d_wr = 1'b0;
  endtask
  task automatic test_read_error;
    exp_t e;
    sb.delete();
    @(negedge clk);
    d_htrans = 2'b10; d_wr = 1'b0; d_addr = 32'h40; rd_fixed = 32'hCAFE0001;
    sb.push_back('{1'b1, 32'hCAFE0001, 1'b1});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({mif.m_hwrite_out, mif.m_hmask_out} !== {1'b0, 4'hF}) begin
          errors++;
          $display("FAIL rderr_mask: got hwrite=%b hmask=%b want 0/1111", mif.m_hwrite_out, mif.m_hmask_out);
        end
        d_htrans = 2'b00;
      end
      if (c == 2) mif.m_hresp_in = 1'b1;
      if (c == 3) mif.m_hresp_in = 1'b0;
      checks++;
      if ({d_hready_out, d_hresp_out} !== {c == 3, c == 3}) begin
        errors++;
        $display("FAIL rderr_pulse_c%0d: got hready=%b hresp=%b want %b/%b", c, d_hready_out, d_hresp_out, c == 3, c == 3);
      end
      if (d_hready_out && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({1'b1, d_rdata_out, d_hresp_out} !== e) begin
          errors++;
          $display("FAIL rderr_data: got rdata=%h resp=%b want rdata=%h resp=%b", d_rdata_out, d_hresp_out, e.rdata, e.resp);
        end
      end
    end
  endtask
  task automatic test_contention;
    exp_t e;
    logic [1:0] want;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    use_fn = 1'b1; i_req = 1'b1; i_addr = 32'h200; d_htrans = 2'b10; d_wr = 1'b0; d_addr = 32'h3000;
    for (int n = 0; n < 2; n++) begin
      sb.push_back('{1'b1, 32'h3000 ^ K, 1'b0});
      sb.push_back('{1'b0, 32'h200 ^ K, 1'b0});
    end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 11) begin
        i_req = 1'b0;
        d_htrans = 2'b00;
      end
      want = (c == 3 || c == 9) ? 2'b01 : (c == 6 || c == 12) ? 2'b10 : 2'b00;
      checks++;
      if ({i_hready_out, d_hready_out} !== want) begin
        errors++;
        $display("FAIL contend_pulse_c%0d: got i/d=%b want %b", c, {i_hready_out, d_hready_out}, want);
      end
      if ((i_hready_out || d_hready_out) && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({d_hready_out, d_hready_out ? d_rdata_out : i_rdata_out, d_hready_out ? d_hresp_out : i_hresp_out} !== e) begin
          errors++;
          $display("FAIL contend_data_c%0d: got own=%b rdata=%h want own=%b rdata=%h", c, d_hready_out,
                   d_hready_out ? d_rdata_out : i_rdata_out, e.own, e.rdata);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL contend_drain: got %0d outstanding want 0", sb.size());
    end
    use_fn = 1'b0;
  endtask
  task automatic test_hung;
    exp_t e;
    logic [1:0] want;
    sb.delete();
    @(negedge clk);
    rd_fixed = 32'h77; mif.m_hready_in = 1'b0; i_req = 1'b1; i_addr = 32'h400;
    sb.push_back('{1'b0, 32'h0, 1'b1});
    sb.push_back('{1'b1, 32'h77, 1'b0});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        d_htrans = 2'b10; d_wr = 1'b0; d_addr = 32'h500;
      end
      if (c <= 5) begin
        checks++;
        if ({mif.m_htrans_out, mif.m_haddr_out} !== {2'b10, 32'h400}) begin
          errors++;
          $display("FAIL hung_addr_c%0d: got htrans=%b haddr=%h want 10/00000400", c, mif.m_htrans_out, mif.m_haddr_out);
        end
      end
      if (c == 6) begin
        i_req = 1'b0;
        mif.m_hready_in = 1'b1;
      end
      if (c == 7) begin
        checks++;
        if ({mif.m_htrans_out, mif.m_haddr_out} !== {2'b10, 32'h500}) begin
          errors++;
          $display("FAIL hung_next_grant: got htrans=%b haddr=%h want 10/00000500", mif.m_htrans_out, mif.m_haddr_out);
        end
        d_htrans = 2'b00;
      end
      want = c == 6 ? 2'b10 : c == 9 ? 2'b01 : 2'b00;
      checks++;
      if ({i_hready_out, d_hready_out} !== want) begin
        errors++;
        $display("FAIL hung_pulse_c%0d: got i/d=%b want %b", c, {i_hready_out, d_hready_out}, want);
      end
      if ((i_hready_out || d_hready_out) && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({d_hready_out, d_hready_out ? d_rdata_out : i_rdata_out, d_hready_out ? d_hresp_out : i_hresp_out} !== e) begin
          errors++;
          $display("FAIL hung_data_c%0d: got own=%b rdata=%h resp=%b want own=%b rdata=%h resp=%b", c, d_hready_out,
                   d_hready_out ? d_rdata_out : i_rdata_out, d_hready_out ? d_hresp_out : i_hresp_out, e.own, e.rdata, e.resp);
        end
      end
    end
  endtask
  task automatic test_async_reset;
    exp_t e;
    sb.delete();
    @(negedge clk);
    d_htrans = 2'b10; d_addr = 32'h600; rd_fixed = 32'h99; mif.m_hready_in = 1'b1;
    @(negedge clk);
    d_htrans = 2'b00;
    @(negedge clk);
    mif.m_hready_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mif.m_htrans_out, mif.m_haddr_out, mif.m_hwrite_out, mif.m_hmask_out, mif.m_hwdata_out,
         i_hready_out, d_hready_out, i_hresp_out, d_hresp_out, i_rdata_out, d_rdata_out} !== '0) begin
      errors++;
      $display("FAIL arst_outputs: got htrans=%b haddr=%h d_rdata=%h d_hready=%b want all zero",
               mif.m_htrans_out, mif.m_haddr_out, d_rdata_out, d_hready_out);
    end
    @(negedge clk);
    rst = 1'b0;
    mif.m_hready_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mif.m_htrans_out, i_hready_out, d_hready_out} !== 4'b0) begin
        errors++;
        $display("FAIL arst_stale_c%0d: got htrans=%b i/d=%b%b want 00/00", c, mif.m_htrans_out, i_hready_out, d_hready_out);
      end
    end
    d_htrans = 2'b10;
    sb.push_back('{1'b1, 32'h99, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) d_htrans = 2'b00;
      checks++;
      if ({i_hready_out, d_hready_out} !== {1'b0, c == 3}) begin
        errors++;
        $display("FAIL arst_retry_c%0d: got i/d=%b want %b", c, {i_hready_out, d_hready_out}, {1'b0, c == 3});
      end
      if (d_hready_out && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({1'b1, d_rdata_out, d_hresp_out} !== e) begin
          errors++;
          $display("FAIL arst_retry_data: got rdata=%h resp=%b want rdata=%h resp=%b", d_rdata_out, d_hresp_out, e.rdata, e.resp);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_write_wait();
    test_read_error();
    test_contention();
    test_hung();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
